// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC launch/capture controller.
package tdc_pkg;

    localparam int TDC_N_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SAMPLE,
        ST_ENCODE,
        ST_HOLD,
        ST_DRAIN
    } tdc_cap_state_t;

    // Width that can hold every count from 0 up to and including n.
    function automatic int tdc_out_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Thermometer-to-binary encoder for the TDC tap snapshot.
// TDC_BUBBLE_FIX_EN selects a bubble-tolerant popcount; otherwise a priority encoder.
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int N     = TDC_N_DEFAULT,
    parameter int OUT_W = tdc_out_w(N)
) (
    input  logic [N-1:0]     therm_i,
    output logic [OUT_W-1:0] count_o
);

`ifdef TDC_BUBBLE_FIX_EN
    // Counting every set tap absorbs isolated bubbles in the code.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + OUT_W'(therm_i[i]);
        end
    end
`else
    // The highest set tap wins; later iterations override earlier ones.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            if (therm_i[i]) begin
                count_o = OUT_W'(i + 1);
            end
        end
    end
`endif

endmodule

// File: rtl/tdc_capture.sv
// Launch-and-capture controller: fires the delay line, double-registers the taps,
// encodes them and hands the count downstream. Encoder style set by TDC_BUBBLE_FIX_EN.
module tdc_capture
    import tdc_pkg::*;
#(
    parameter int N     = TDC_N_DEFAULT,
    parameter int OUT_W = tdc_out_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             pulse_o,
    input  logic [N-1:0]     taps_i,
    output logic [OUT_W-1:0] meas_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);

    tdc_cap_state_t   state;
    logic [N-1:0]     cap1;
    logic [N-1:0]     cap2;
    logic [OUT_W-1:0] enc_count;

    // Only cap2 reaches the encoder; cap1 is allowed to go metastable.
    tdc_therm_encoder #(
        .N     (N),
        .OUT_W (OUT_W)
    ) u_encoder (
        .therm_i (cap2),
        .count_o (enc_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cap1       <= '0;
            cap2       <= '0;
            pulse_o    <= 1'b0;
            meas_o     <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        pulse_o <= 1'b1;
                        busy_o  <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cap1  <= taps_i;
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    cap2  <= cap1;
                    state <= ST_ENCODE;
                end
                ST_ENCODE: begin
                    meas_o     <= enc_count;
                    overflow_o <= cap2[N-1];
                    valid_o    <= 1'b1;
                    pulse_o    <= 1'b0;
                    state      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (valid_o && ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Stay here until the line has emptied so the next launch starts clean.
                    cap1 <= taps_i;
                    cap2 <= cap1;
                    if (cap2 == '0) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    pulse_o <= 1'b0;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_capture.sv
// Self-checking bench for tdc_capture: vector table, hand-written corner cases and
// randomized measurements against a count model that follows the build's TDC_BUBBLE_FIX_EN.
module tb_tdc_capture;
    import tdc_pkg::*;

    localparam int N     = TDC_N_DEFAULT;
    localparam int OUT_W = tdc_out_w(N);

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic             pulse_o;
    logic [N-1:0]     taps_i;
    logic [OUT_W-1:0] meas_o;
    logic             overflow_o;
    logic             valid_o;
    logic             ready_i;
    logic             busy_o;

    int assert_count;
    int fail_count;

    typedef struct {
        logic [N-1:0] taps;
        int           rdy_delay;
        int           exp_meas;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    tdc_capture #(
        .N     (N),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .pulse_o    (pulse_o),
        .taps_i     (taps_i),
        .meas_o     (meas_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected count from the thermometer rules, independent of the RTL structure.
    function automatic int ref_count(input logic [N-1:0] t);
`ifdef TDC_BUBBLE_FIX_EN
        return $countones(t);
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (t[i]) return i + 1;
        end
        return 0;
`endif
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full measurement: launch, capture t at E1, wait rdy_delay HOLD cycles,
    // optionally poke start during HOLD, optionally keep the line full in DRAIN.
    task automatic apply_stimulus(input logic [N-1:0] t, input int rdy_delay, input int exp_meas,
                                  input logic exp_ovf, input bit poke_start, input int drain_hold);
        int waited;
        ready_i = (rdy_delay == 0);
        taps_i  = '0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_output("pulse_after_e0", 64'(pulse_o), 64'd1);
        check_output("busy_after_e0", 64'(busy_o), 64'd1);
        taps_i = t;
        tick();
        if (drain_hold == 0) taps_i = '0;
        tick();
        check_output("valid_before_e3", 64'(valid_o), 64'd0);
        check_output("pulse_before_e3", 64'(pulse_o), 64'd1);
        tick();
        check_output("valid_after_e3", 64'(valid_o), 64'd1);
        check_output("meas", 64'(meas_o), 64'(exp_meas));
        check_output("overflow", 64'(overflow_o), 64'(exp_ovf));
        check_output("pulse_low_after_e3", 64'(pulse_o), 64'd0);
        for (int i = 0; i < rdy_delay; i++) begin
            if (poke_start && i == 1) start_i = 1'b1;
            tick();
            start_i = 1'b0;
            check_output("hold_valid", 64'(valid_o), 64'd1);
            check_output("hold_meas", 64'(meas_o), 64'(exp_meas));
            check_output("hold_overflow", 64'(overflow_o), 64'(exp_ovf));
            check_output("hold_no_pulse", 64'(pulse_o), 64'd0);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_output("valid_after_handshake", 64'(valid_o), 64'd0);
        check_output("meas_kept_after_handshake", 64'(meas_o), 64'(exp_meas));
        if (drain_hold > 0) begin
            for (int i = 0; i < drain_hold; i++) tick();
            check_output("drain_busy_while_full", 64'(busy_o), 64'd1);
            taps_i = '0;
        end
        waited = 0;
        while (busy_o && waited < 20) begin
            tick();
            waited++;
        end
        check_output("drain_to_idle", 64'(busy_o), 64'd0);
        check_output("idle_pulse_low", 64'(pulse_o), 64'd0);
    endtask

    initial begin
        logic [N-1:0] t;
        logic [N-1:0] all_ones;
        int           k;

        assert_count = 0;
        fail_count   = 0;
        all_ones     = '1;
        rst_n   = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        taps_i  = '0;

        vecs.push_back('{taps: 64'h0000_0000_0000_FFFF, rdy_delay: 0, exp_meas: 16, exp_ovf: 1'b0});
        vecs.push_back('{taps: 64'h0,                   rdy_delay: 0, exp_meas: 0,  exp_ovf: 1'b0});
        vecs.push_back('{taps: 64'h1,                   rdy_delay: 1, exp_meas: 1,  exp_ovf: 1'b0});
        vecs.push_back('{taps: 64'h7FFF_FFFF_FFFF_FFFF, rdy_delay: 0, exp_meas: 63, exp_ovf: 1'b0});
        vecs.push_back('{taps: all_ones,                rdy_delay: 2, exp_meas: 64, exp_ovf: 1'b1});
`ifdef TDC_BUBBLE_FIX_EN
        vecs.push_back('{taps: 64'h1B,                  rdy_delay: 0, exp_meas: 4,  exp_ovf: 1'b0});
        vecs.push_back('{taps: 64'h8000_0000_0000_0000, rdy_delay: 0, exp_meas: 1,  exp_ovf: 1'b1});
`else
        vecs.push_back('{taps: 64'h1B,                  rdy_delay: 0, exp_meas: 5,  exp_ovf: 1'b0});
        vecs.push_back('{taps: 64'h8000_0000_0000_0000, rdy_delay: 0, exp_meas: 64, exp_ovf: 1'b1});
`endif

        #12;
        check_output("reset_pulse", 64'(pulse_o), 64'd0);
        check_output("reset_valid", 64'(valid_o), 64'd0);
        check_output("reset_meas", 64'(meas_o), 64'd0);
        check_output("reset_overflow", 64'(overflow_o), 64'd0);
        check_output("reset_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_output("idle_busy", 64'(busy_o), 64'd0);
        check_output("idle_pulse", 64'(pulse_o), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].taps, vecs[i].rdy_delay, vecs[i].exp_meas, vecs[i].exp_ovf, 1'b0, 0);
        end

        $display("[TB] backpressure with start poke during hold");
        apply_stimulus(64'h0000_0000_00FF_FFFF, 5, 24, 1'b0, 1'b1, 0);
        check_output("no_second_launch", 64'(busy_o), 64'd0);

        $display("[TB] overflow with slow drain");
        apply_stimulus(all_ones, 0, 64, 1'b1, 1'b0, 5);

        $display("[TB] reset in the middle of a measurement");
        taps_i  = 64'hFF;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midreset_pulse", 64'(pulse_o), 64'd0);
        check_output("midreset_valid", 64'(valid_o), 64'd0);
        check_output("midreset_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(64'h0000_0000_0000_0FFF, 0, 12, 1'b0, 1'b0, 0);

        $display("[TB] randomized measurements");
        for (int n = 0; n < 25; n++) begin
            k = $urandom_range(0, N);
            t = (k == 0) ? '0 : (all_ones >> (N - k));
            if (k > 2 && $urandom_range(0, 2) == 0) begin
                t[$urandom_range(0, k - 2)] ^= 1'b1;
            end
            apply_stimulus(t, $urandom_range(0, 3), ref_count(t), t[N-1], 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
